// File: rtl/fifo_credit_feeder.sv
// Credit-based write issuer feeding memory_core in FIFO mode: a 2-entry skid buffer
// drains into wen_out/data_out only while free FIFO credits remain.
module fifo_credit_feeder #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  input  logic          flush,
  input  logic [CW-1:0] depth,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          rd_done,
  output logic          wen_out,
  output logic [DW-1:0] data_out,
  output logic [CW-1:0] credits,
  output logic [1:0]    buf_cnt,
  output logic          cfg_err,
  output logic          ovf_err
);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [2];
  logic          wr_ptr, rd_ptr;
  logic [CW-1:0] depth_q;
  logic          run, accept, issue, rd_ret;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LOAD;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (depth != '0) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_LOAD;
    endcase
  end

  // All handshake outputs derive from registered state, so in_valid never reaches wen_out.
  always_comb begin
    run      = (state == S_RUN);
    in_ready = run && (buf_cnt != 2'd2) && !flush;
    accept   = in_valid && in_ready && clk_en;
    issue    = run && clk_en && (buf_cnt != 2'd0) && (credits != '0) && !flush;
    rd_ret   = run && clk_en && rd_done;
    wen_out  = issue;
    data_out = (buf_cnt != 2'd0) ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      buf_cnt <= 2'd0;
    end else if (clk_en) begin
      if (flush) begin
        wr_ptr  <= 1'b0;
        rd_ptr  <= 1'b0;
        buf_cnt <= 2'd0;
      end else begin
        if (accept) wr_ptr <= ~wr_ptr;
        if (issue)  rd_ptr <= ~rd_ptr;
        case ({accept, issue})
          2'b10:   buf_cnt <= buf_cnt + 2'd1;
          2'b01:   buf_cnt <= buf_cnt - 2'd1;
          default: buf_cnt <= buf_cnt;
        endcase
      end
    end
  end

  // A returned credit that would exceed the configured depth is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= '0;
      depth_q <= '0;
      cfg_err <= 1'b0;
      ovf_err <= 1'b0;
    end else if (clk_en) begin
      if (state == S_LOAD) begin
        if (depth != '0) begin
          credits <= depth;
          depth_q <= depth;
        end else begin
          cfg_err <= 1'b1;
        end
      end else begin
        if (rd_ret && !issue) begin
          if (credits == depth_q) ovf_err <= 1'b1;
          else                    credits <= credits + CW'(1);
        end else if (issue && !rd_ret) begin
          credits <= credits - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_credit_feeder.sv
// Directed bench for fifo_credit_feeder: reset, credit-limited issue, credit return,
// overflow, clock-enable freeze, flush, mid-burst reset and zero-depth configuration.
module tb_fifo_credit_feeder;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset, clk_en, flush, in_valid, rd_done;
  logic [CW-1:0] depth;
  logic [DW-1:0] in_data;
  logic          in_ready, wen_out, cfg_err, ovf_err;
  logic [DW-1:0] data_out;
  logic [CW-1:0] credits;
  logic [1:0]    buf_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  fifo_credit_feeder #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .depth(depth),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .rd_done(rd_done),
    .wen_out(wen_out), .data_out(data_out), .credits(credits), .buf_cnt(buf_cnt),
    .cfg_err(cfg_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [CW-1:0] d);
    reset = 1'b1; clk_en = 1'b1; flush = 1'b0; in_valid = 1'b0; rd_done = 1'b0;
    in_data = '0; depth = d;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b1; flush = 1'b0; in_valid = 1'b0; rd_done = 1'b0;
    in_data = '0; depth = 16'd4;
    tick(); tick();
    @(negedge clk);
    n_checks++; if (wen_out !== 1'b0) begin n_fail++; $display("FAIL rst_wen got %0b want 0", wen_out); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %0b want 0", in_ready); end
    n_checks++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL rst_data got %h want 0000", data_out); end
    n_checks++; if (credits !== 16'd0) begin n_fail++; $display("FAIL rst_credits got %0d want 0", credits); end
    n_checks++; if (buf_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_bufcnt got %0d want 0", buf_cnt); end
    n_checks++; if ({cfg_err, ovf_err} !== 2'b00) begin n_fail++; $display("FAIL rst_errs got %b want 00", {cfg_err, ovf_err}); end
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if (credits !== 16'd4) begin n_fail++; $display("FAIL load_credits got %0d want 4", credits); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready got %0b want 1", in_ready); end
    n_checks++; if (wen_out !== 1'b0) begin n_fail++; $display("FAIL load_wen got %0b want 0", wen_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_w;
    int unsigned idx = 0;
    logic acc;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (idx < 6);
      in_data  = 16'h11 + 16'(idx);
      @(negedge clk);
      if (wen_out === 1'b1) got.push_back(data_out);
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (idx != 6) begin n_fail++; $display("FAIL b2b_accepted got %0d want 6", idx); end
    n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL b2b_pulses got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      exp_w = 16'h11 + 16'(i);
      n_checks++;
      if (i >= got.size() || got[i] !== exp_w) begin
        n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, (i < got.size()) ? got[i] : 16'hxxxx, exp_w);
      end
    end
    n_checks++; if (credits !== 16'd0) begin n_fail++; $display("FAIL b2b_credits got %0d want 0", credits); end
    n_checks++; if (buf_cnt !== 2'd2) begin n_fail++; $display("FAIL b2b_bufcnt got %0d want 2", buf_cnt); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready got %0b want 0", in_ready); end
    tick();
  endtask

  task automatic test_credit_return();
    rd_done = 1'b1;
    @(negedge clk);
    n_checks++; if (wen_out !== 1'b0) begin n_fail++; $display("FAIL ret_nowen got %0b want 0", wen_out); end
    tick();
    rd_done = 1'b0;
    @(negedge clk);
    n_checks++; if (credits !== 16'd1) begin n_fail++; $display("FAIL ret_credit1 got %0d want 1", credits); end
    n_checks++; if (wen_out !== 1'b1) begin n_fail++; $display("FAIL ret_wen got %0b want 1", wen_out); end
    n_checks++; if (data_out !== 16'h15) begin n_fail++; $display("FAIL ret_data got %h want 0015", data_out); end
    tick();
    @(negedge clk);
    n_checks++; if (credits !== 16'd0) begin n_fail++; $display("FAIL ret_credit0 got %0d want 0", credits); end
    n_checks++; if (buf_cnt !== 2'd1) begin n_fail++; $display("FAIL ret_bufcnt got %0d want 1", buf_cnt); end
    n_checks++; if (data_out !== 16'h16) begin n_fail++; $display("FAIL ret_head got %h want 0016", data_out); end
    tick();
  endtask

  task automatic test_overflow();
    do_reset(16'd2);
    in_valid = 1'b1; in_data = 16'hA1;
    tick();
    in_valid = 1'b0; rd_done = 1'b1;
    @(negedge clk);
    n_checks++; if ({wen_out, data_out} !== {1'b1, 16'hA1}) begin n_fail++; $display("FAIL ovf_issue got %b/%h want 1/00a1", wen_out, data_out); end
    tick();
    @(negedge clk);
    n_checks++; if (credits !== 16'd2) begin n_fail++; $display("FAIL ovf_same_cycle got %0d want 2", credits); end
    n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %0b want 0", ovf_err); end
    n_checks++; if (buf_cnt !== 2'd0) begin n_fail++; $display("FAIL ovf_bufcnt got %0d want 0", buf_cnt); end
    tick();
    rd_done = 1'b0;
    @(negedge clk);
    n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", ovf_err); end
    n_checks++; if (credits !== 16'd2) begin n_fail++; $display("FAIL ovf_hold got %0d want 2", credits); end
    tick();
  endtask

  task automatic test_clk_en();
    do_reset(16'd1);
    in_valid = 1'b1; in_data = 16'hB1;
    tick();
    in_data = 16'hB2;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({credits, buf_cnt} !== {16'd0, 2'd1}) begin n_fail++; $display("FAIL ce_setup got %0d/%0d want 0/1", credits, buf_cnt); end
    tick();
    clk_en = 1'b0; in_valid = 1'b1; in_data = 16'hB3; rd_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (wen_out !== 1'b0) begin n_fail++; $display("FAIL ce_wen[%0d] got %0b want 0", i, wen_out); end
      tick();
    end
    clk_en = 1'b1; in_valid = 1'b0; rd_done = 1'b0;
    @(negedge clk);
    n_checks++; if (credits !== 16'd0) begin n_fail++; $display("FAIL ce_credits got %0d want 0", credits); end
    n_checks++; if (buf_cnt !== 2'd1) begin n_fail++; $display("FAIL ce_bufcnt got %0d want 1", buf_cnt); end
    n_checks++; if (data_out !== 16'hB2) begin n_fail++; $display("FAIL ce_head got %h want 00b2", data_out); end
    tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    @(negedge clk);
    n_checks++; if ({wen_out, data_out, credits} !== {1'b1, 16'hB2, 16'd1}) begin n_fail++; $display("FAIL ce_resume got %b/%h/%0d want 1/00b2/1", wen_out, data_out, credits); end
    tick();
    @(negedge clk);
    n_checks++; if ({buf_cnt, credits} !== {2'd0, 16'd0}) begin n_fail++; $display("FAIL ce_drain got %0d/%0d want 0/0", buf_cnt, credits); end
    tick();
  endtask

  task automatic test_flush_reset_cfg();
    do_reset(16'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'hC1 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({buf_cnt, in_ready} !== {2'd2, 1'b0}) begin n_fail++; $display("FAIL fl_setup got %0d/%0b want 2/0", buf_cnt, in_ready); end
    tick();
    flush = 1'b1;
    @(negedge clk);
    n_checks++; if ({in_ready, wen_out} !== 2'b00) begin n_fail++; $display("FAIL fl_block got %b want 00", {in_ready, wen_out}); end
    tick();
    flush = 1'b0;
    @(negedge clk);
    n_checks++; if (buf_cnt !== 2'd0) begin n_fail++; $display("FAIL fl_bufcnt got %0d want 0", buf_cnt); end
    n_checks++; if (credits !== 16'd0) begin n_fail++; $display("FAIL fl_credits got %0d want 0", credits); end
    n_checks++; if ({data_out, in_ready} !== {16'h0, 1'b1}) begin n_fail++; $display("FAIL fl_after got %h/%0b want 0000/1", data_out, in_ready); end
    tick();

    do_reset(16'd3);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 16'hD1 + 16'(i);
      tick();
    end
    reset = 1'b1;
    tick();
    @(negedge clk);
    n_checks++; if ({wen_out, in_ready, data_out} !== {1'b0, 1'b0, 16'h0}) begin n_fail++; $display("FAIL mr_outs got %b/%b/%h want 0/0/0000", wen_out, in_ready, data_out); end
    n_checks++; if ({credits, buf_cnt, cfg_err, ovf_err} !== {16'd0, 2'd0, 2'b00}) begin n_fail++; $display("FAIL mr_state got %0d/%0d/%b%b want 0/0/00", credits, buf_cnt, cfg_err, ovf_err); end
    tick();

    do_reset(16'd0);
    tick();
    @(negedge clk);
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err got %0b want 1", cfg_err); end
    n_checks++; if ({in_ready, credits} !== {1'b0, 16'd0}) begin n_fail++; $display("FAIL cfg_hold got %0b/%0d want 0/0", in_ready, credits); end
    tick();
    depth = 16'd3;
    tick();
    depth = 16'd7;
    @(negedge clk);
    n_checks++; if ({cfg_err, in_ready, credits} !== {1'b1, 1'b1, 16'd3}) begin n_fail++; $display("FAIL cfg_late got %b/%b/%0d want 1/1/3", cfg_err, in_ready, credits); end
    tick();
    @(negedge clk);
    n_checks++; if (credits !== 16'd3) begin n_fail++; $display("FAIL cfg_ignore got %0d want 3", credits); end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_credit_return();
    test_overflow();
    test_clk_en();
    test_flush_reset_cfg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
